// File: rtl/dds_chirp_burst_pkg.sv
// Shared FSM states, quadrant codes and the elaboration-time quarter-sine table generator.
// The table is built from a 128-bit fixed-point Taylor series so no init file is needed.
package dds_chirp_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // pi scaled by 2^60
  localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;

  // round((2^(outw-1)-1) * sin(pi/2 * (k+0.5) / 2^addrw)), constant-evaluated only
  function automatic logic [63:0] lut_entry(input int k, input int addrw, input int outw);
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] t;
    logic [127:0] s;
    logic [127:0] full;
    x  = (128'(PI_Q60) * 128'(2 * k + 1)) >> (addrw + 2);
    x2 = (x * x) >> 60;
    t  = x;
    s  = x;
    for (int n = 3; n <= 27; n += 2) begin
      t = ((t * x2) >> 60) / 128'((n - 1) * n);
      if ((((n - 1) / 2) % 2) == 1) s = s - t;
      else                          s = s + t;
    end
    full = 128'((64'd1 << (outw - 1)) - 64'd1);
    return 64'(((full * s) + (128'd1 << 59)) >> 60);
  endfunction

endpackage

// File: rtl/dds_chirp_burst_quarter_lut.sv
// Quarter-wave sine ROM with quadrant fold; registers magnitude and sign on en.
// Latency 1 en-qualified clock; no backpressure, holds when en is low.
module dds_chirp_burst_quarter_lut
  import dds_chirp_burst_pkg::*;
#(
  parameter int OUTW     = 18,
  parameter int LUTADDRW = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [31:0]            phase,
  output logic signed [OUTW-1:0] sample
);

  localparam int LUT_DEPTH = 1 << LUTADDRW;

  logic [OUTW-2:0]     rom [LUT_DEPTH];
  logic [1:0]          quad;
  logic [LUTADDRW-1:0] addr;
  logic [OUTW-2:0]     mag_q, mag_d;
  logic                neg_q, neg_d;
  logic signed [OUTW-1:0] pos;
  logic                unused_phase_lsbs;

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam logic [63:0] ENT = lut_entry(k, LUTADDRW, OUTW);
    assign rom[k] = ENT[OUTW-2:0];
  end

  assign quad = phase[31:30];
  assign addr = (quad == QUAD_1 || quad == QUAD_3) ? ~phase[29:30-LUTADDRW]
                                                   : phase[29:30-LUTADDRW];
  assign unused_phase_lsbs = ^phase[29-LUTADDRW:0];

  always_comb begin
    mag_d = mag_q;
    neg_d = neg_q;
    if (en) begin
      mag_d = rom[addr];
      neg_d = (quad == QUAD_2) || (quad == QUAD_3);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mag_q <= '0;
      neg_q <= 1'b0;
    end else begin
      mag_q <= mag_d;
      neg_q <= neg_d;
    end
  end

  assign pos    = {1'b0, mag_q};
  assign sample = neg_q ? -pos : pos;

endmodule

// File: rtl/dds_chirp_burst.sv
// Multi-channel linear-chirp DDS burst generator with per-channel offset and gain.
// Output latency 2 enableclk ticks from issue; no backpressure, all state holds between ticks.
module dds_chirp_burst
  import dds_chirp_burst_pkg::*;
#(
  parameter int          NCH      = 2,
  parameter int          OUTW     = 18,
  parameter int          LUTADDRW = 10,
  parameter int          AMPW     = 16,
  parameter int          CNTW     = 24,
  parameter logic [31:0] START_PH = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enableclk,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           phaseinc0,
  input  logic [31:0]           chirpinc,
  input  logic [CNTW-1:0]       nsamples,
  input  logic [AMPW-1:0]       amplitude,
  input  logic [NCH*32-1:0]     phaseoffset,
  output logic [NCH*OUTW-1:0]   outsine,
  output logic                  outvalid,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = OUTW + AMPW + 1;

  state_t              state_q, state_d;
  logic [31:0]         phase_q, phase_d;
  logic [31:0]         inc_q, inc_d;
  logic [31:0]         chirp_q, chirp_d;
  logic [CNTW-1:0]     nsamp_q, nsamp_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [AMPW-1:0]     amp_q, amp_d;
  logic                v1_q, v1_d;
  logic                outvalid_q, outvalid_d;
  logic                done_q, done_d;
  logic [NCH*OUTW-1:0] outsine_q, outsine_d;
  logic [NCH*OUTW-1:0] scaled;
  logic                issue;

  assign issue = enableclk && (state_q == ST_RUN);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [31:0]            pt;
    logic signed [OUTW-1:0] s;
    logic signed [PW-1:0]   prod;
    logic                   unused_prod;

    assign pt = phase_q + phaseoffset[32*i +: 32];

    dds_chirp_burst_quarter_lut #(
      .OUTW     (OUTW),
      .LUTADDRW (LUTADDRW)
    ) u_lut (
      .clock  (clock),
      .reset  (reset),
      .en     (issue),
      .phase  (pt),
      .sample (s)
    );

    // Full-width signed product; taking bits from AMPW up is an arithmetic floor shift.
    assign prod = PW'(s) * PW'($signed({1'b0, amp_q}));
    assign scaled[OUTW*i +: OUTW] = prod[AMPW +: OUTW];
    assign unused_prod = ^{prod[PW-1], prod[AMPW-1:0]};
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    chirp_d    = chirp_q;
    nsamp_d    = nsamp_q;
    cnt_d      = cnt_q;
    amp_d      = amp_q;
    v1_d       = v1_q;
    outvalid_d = 1'b0;
    done_d     = 1'b0;
    outsine_d  = outsine_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          phase_d = START_PH;
          inc_d   = phaseinc0;
          chirp_d = chirpinc;
          nsamp_d = nsamples;
          amp_d   = amplitude;
          cnt_d   = '0;
          state_d = (nsamples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (enableclk) begin
          phase_d = phase_q + inc_q;
          inc_d   = inc_q + chirp_q;
          cnt_d   = cnt_q + CNTW'(1);
          if (cnt_q == nsamp_q - CNTW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enableclk && v1_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (enableclk) begin
      v1_d = (state_q == ST_RUN);
      if (v1_q) begin
        outvalid_d = 1'b1;
        outsine_d  = scaled;
      end
    end

    if (abort) begin
      state_d    = ST_IDLE;
      v1_d       = 1'b0;
      outvalid_d = 1'b0;
      done_d     = 1'b0;
      outsine_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= START_PH;
      inc_q      <= '0;
      chirp_q    <= '0;
      nsamp_q    <= '0;
      cnt_q      <= '0;
      amp_q      <= '0;
      v1_q       <= 1'b0;
      outvalid_q <= 1'b0;
      done_q     <= 1'b0;
      outsine_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      chirp_q    <= chirp_d;
      nsamp_q    <= nsamp_d;
      cnt_q      <= cnt_d;
      amp_q      <= amp_d;
      v1_q       <= v1_d;
      outvalid_q <= outvalid_d;
      done_q     <= done_d;
      outsine_q  <= outsine_d;
    end
  end

  assign outsine  = outsine_q;
  assign outvalid = outvalid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_dds_chirp_burst.sv
// Bench for dds_chirp_burst: closed-form phase model, $sin-derived LUT, randomized bursts.
module tb_dds_chirp_burst;

  localparam int          NCH      = 2;
  localparam int          OUTW     = 18;
  localparam int          LUTADDRW = 10;
  localparam int          AMPW     = 16;
  localparam int          CNTW     = 24;
  localparam logic [31:0] START_PH = 32'h0000_0000;
  localparam int          LUTN     = 1 << LUTADDRW;

  logic                clock = 1'b0;
  logic                reset, enableclk, start, abort;
  logic [31:0]         phaseinc0, chirpinc;
  logic [CNTW-1:0]     nsamples;
  logic [AMPW-1:0]     amplitude;
  logic [NCH*32-1:0]   phaseoffset;
  logic [NCH*OUTW-1:0] outsine;
  logic                outvalid, busy, done;

  dds_chirp_burst #(
    .NCH(NCH), .OUTW(OUTW), .LUTADDRW(LUTADDRW), .AMPW(AMPW), .CNTW(CNTW), .START_PH(START_PH)
  ) dut (
    .clock(clock), .reset(reset), .enableclk(enableclk), .start(start), .abort(abort),
    .phaseinc0(phaseinc0), .chirpinc(chirpinc), .nsamples(nsamples), .amplitude(amplitude),
    .phaseoffset(phaseoffset), .outsine(outsine), .outvalid(outvalid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int     nchk = 0, nerr = 0;
  int     lut_ref [LUTN];
  longint exp0[$], exp1[$], cap0[$], cap1[$];
  int     valid_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int     tick_div = 1, tick_ctr = 0;
  bit     tick_hold = 1'b0;

  task automatic check(input string tag, input longint got, input longint want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic longint ref_sample(input logic [31:0] ph, input longint amp);
    int     a;
    longint mag;
    a = int'(ph[29:30-LUTADDRW]);
    if (ph[30]) a = LUTN - 1 - a;
    mag = lut_ref[a];
    if (ph[31]) mag = -mag;
    return (mag * amp) >>> AMPW;
  endfunction

  // Phase of sample n: START + n*inc0 + chirp*n(n-1)/2, all mod 2^32.
  task automatic build_expect(input logic [31:0] inc0, input logic [31:0] chirp,
                              input int ns, input int amp);
    logic [31:0] ph;
    exp0.delete();
    exp1.delete();
    for (int n = 0; n < ns; n++) begin
      ph = START_PH + inc0 * 32'(n) + chirp * 32'((n * (n - 1)) / 2);
      exp0.push_back(ref_sample(ph + phaseoffset[31:0], longint'(amp)));
      exp1.push_back(ref_sample(ph + phaseoffset[63:32], longint'(amp)));
    end
  endtask

  task automatic step();
    longint s0, s1;
    @(negedge clock);
    if (outvalid) begin
      s0 = $signed(outsine[OUTW-1:0]);
      s1 = $signed(outsine[2*OUTW-1:OUTW]);
      cap0.push_back(s0);
      cap1.push_back(s1);
      valid_cnt++;
      if (exp0.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        check("ch0_sample", s0, exp0.pop_front());
        check("ch1_sample", s1, exp1.pop_front());
      end
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    tick_ctr++;
    enableclk = !tick_hold && ((tick_ctr % tick_div) == 0);
  endtask

  task automatic start_burst(input logic [31:0] inc0, input logic [31:0] chirp,
                             input int ns, input int amp);
    valid_cnt = 0; done_cnt = 0; busy_cnt = 0;
    cap0.delete(); cap1.delete();
    build_expect(inc0, chirp, ns, amp);
    phaseinc0 = inc0; chirpinc = chirp; nsamples = CNTW'(ns); amplitude = AMPW'(amp);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      step();
      i++;
    end
    check("done_seen", done_cnt, 1);
  endtask

  task automatic wait_valids(input int target, input int budget);
    int i;
    i = 0;
    while (valid_cnt < target && i < budget) begin
      step();
      i++;
    end
  endtask

  task automatic run_normal(input logic [31:0] inc0, input logic [31:0] chirp,
                            input int ns, input int amp, input int div);
    tick_div = div;
    start_burst(inc0, chirp, ns, amp);
    wait_done(4000);
    check("busy_at_done", busy, 0);
    check("valid_count", valid_cnt, ns);
    check("leftover", exp0.size(), 0);
    step();
    check("done_pulse_width", done, 0);
  endtask

  initial begin
    longint hold0, want;
    longint pat [4];
    int     vc;

    for (int k = 0; k < LUTN; k++)
      lut_ref[k] = $rtoi(real'((1 << (OUTW - 1)) - 1) *
                         $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(LUTN)) + 0.5);

    reset = 1'b1; start = 1'b0; abort = 1'b0; enableclk = 1'b0;
    phaseinc0 = '0; chirpinc = '0; nsamples = '0; amplitude = '0; phaseoffset = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_outvalid", outvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_outsine", longint'(outsine), 0);

    // Quarter-turn tone: L0, L1023, -L0, -L1023 repeating, scaled by near-unity gain
    phaseoffset = '0;
    run_normal(32'h4000_0000, 32'h0, 8, 65535, 4);
    pat[0] = (longint'(lut_ref[0]) * 65535) >>> 16;
    pat[1] = (longint'(lut_ref[LUTN-1]) * 65535) >>> 16;
    pat[2] = (-longint'(lut_ref[0]) * 65535) >>> 16;
    pat[3] = (-longint'(lut_ref[LUTN-1]) * 65535) >>> 16;
    for (int n = 0; n < 8; n++) begin
      want = pat[n % 4];
      if (n < cap0.size()) check("t1_pattern", cap0[n], want);
      else check("t1_missing", n, -1);
    end

    phaseoffset = {$urandom, $urandom};
    run_normal(32'h0, 32'h0100_0000, 16, int'($urandom_range(1, 65535)), 2);

    // Zero-length burst
    tick_div = 3;
    start_burst(32'h1234_5678, 32'h0, 0, 1000);
    check("t3_busy_c1", busy, 1);
    check("t3_done_c1", done, 0);
    step();
    check("t3_done_c2", done, 1);
    check("t3_busy_c2", busy, 0);
    step();
    check("t3_done_c3", done, 0);
    check("t3_no_valid", valid_cnt, 0);
    check("t3_busy_len", busy_cnt, 1);

    // Abort after the fifth sample
    tick_div = 2;
    phaseoffset = {$urandom, $urandom};
    start_burst($urandom, $urandom, 12, int'($urandom_range(0, 65535)));
    wait_valids(5, 2000);
    check("t4_reach5", valid_cnt, 5);
    abort = 1'b1;
    exp0.delete(); exp1.delete();
    step();
    abort = 1'b0;
    check("t4_outsine_zero", longint'(outsine), 0);
    check("t4_busy", busy, 0);
    check("t4_outvalid", outvalid, 0);
    check("t4_done", done, 0);
    repeat (40) step();
    check("t4_valid_total", valid_cnt, 5);
    check("t4_no_done", done_cnt, 0);
    phaseoffset = {$urandom, $urandom};
    run_normal($urandom, $urandom, 9, int'($urandom_range(0, 65535)), 2);

    // Channel 1 a quarter turn ahead sees channel 0's next sample
    phaseoffset = {32'h4000_0000, 32'h0};
    run_normal(32'h4000_0000, 32'h0, 10, int'($urandom_range(1, 65535)), 1);
    for (int n = 0; n < 9; n++)
      if (n + 1 < cap0.size()) check("t5_ch1_lead", cap1[n], cap0[n+1]);

    // Start while busy is ignored; ticks stop for 50 clocks mid-burst
    tick_div = 3;
    phaseoffset = {$urandom, $urandom};
    start_burst($urandom, $urandom, 20, int'($urandom_range(0, 65535)));
    wait_valids(6, 2000);
    check("t6_reach6", valid_cnt, 6);
    phaseinc0 = $urandom; chirpinc = $urandom; nsamples = CNTW'(3); amplitude = AMPW'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    tick_hold = 1'b1;
    enableclk = 1'b0;
    hold0 = longint'(outsine);
    vc = valid_cnt;
    repeat (50) step();
    check("t6_frozen_out", longint'(outsine), hold0);
    check("t6_no_valid_hold", valid_cnt, vc);
    check("t6_busy_hold", busy, 1);
    tick_hold = 1'b0;
    wait_done(4000);
    check("t6_valid_count", valid_cnt, 20);
    check("t6_leftover", exp0.size(), 0);
    repeat (5) step();
    check("t6_no_restart", busy, 0);

    for (int r = 0; r < 6; r++) begin
      phaseoffset = {$urandom, $urandom};
      run_normal($urandom, $urandom, int'($urandom_range(1, 20)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
